// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding, width defaults and counter sizing for the sequential divider.
package seq_divider_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W = $clog2(WIDTH_DEF);
  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/seq_divider_step.sv
// div_step: one restoring iteration; shift in a dividend bit, trial subtract, keep or restore.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q
);
  logic [WIDTH+1:0] w_diff;
  assign w_diff = {i_rem, i_bit} - {2'b00, i_div};
  assign o_q    = ~w_diff[WIDTH+1];
  assign o_rem  = w_diff[WIDTH+1] ? {i_rem[WIDTH-1:0], i_bit} : w_diff[WIDTH:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring signed/unsigned divider producing one quotient bit per cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Rem,
  output logic             Z,
  output logic             V,
  output logic             DZ
);
  localparam int CW = cnt_bits(WIDTH);
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dq, r_b, r_q, r_rem;
  logic [WIDTH:0]   r_part;
  logic             r_neg_q, r_neg_r, r_z, r_v, r_dz;
  logic             w_a_neg, w_b_neg, w_dz, w_ov, w_accept, w_last, w_qbit;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_qmag, w_rmag, w_qfin, w_rfin;
  logic [WIDTH:0]   w_part_next;
  assign w_a_neg  = Sign & A[WIDTH-1];
  assign w_b_neg  = Sign & B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -A : A;
  assign w_b_mag  = w_b_neg ? -B : B;
  assign w_dz     = B == '0;
  assign w_ov     = Sign & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (&B);
  assign w_accept = start & (r_state != S_CALC);
  assign w_last   = r_cnt == CW'(WIDTH-1);
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_part),
    .i_bit (r_dq[WIDTH-1]),
    .i_div (r_b),
    .o_rem (w_part_next),
    .o_q   (w_qbit)
  );
  // quotient bits shift into the dividend register as its bits are consumed
  assign w_qmag = {r_dq[WIDTH-2:0], w_qbit};
  assign w_rmag = w_part_next[WIDTH-1:0];
  assign w_qfin = r_neg_q ? -w_qmag : w_qmag;
  assign w_rfin = r_neg_r ? -w_rmag : w_rmag;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dq    <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_q     <= '0;
      r_rem   <= '0;
      r_z     <= 1'b0;
      r_v     <= 1'b0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_dq    <= w_a_mag;
      r_b     <= w_b_mag;
      r_part  <= '0;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (w_dz) begin
        r_state <= S_DONE;
        r_q     <= '1;
        r_rem   <= A;
        r_z     <= 1'b0;
        r_v     <= 1'b0;
        r_dz    <= 1'b1;
      end else if (w_ov) begin
        r_state <= S_DONE;
        r_q     <= A;
        r_rem   <= '0;
        r_z     <= 1'b0;
        r_v     <= 1'b1;
        r_dz    <= 1'b0;
      end else begin
        r_state <= S_CALC;
      end
    end else if (r_state == S_CALC) begin
      r_dq   <= w_qmag;
      r_part <= w_part_next;
      r_cnt  <= w_last ? r_cnt : r_cnt + 1'b1;
      if (w_last) begin
        r_state <= S_DONE;
        r_q     <= w_qfin;
        r_rem   <= w_rfin;
        r_z     <= w_qfin == '0;
        r_v     <= 1'b0;
        r_dz    <= 1'b0;
      end
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
    end
  end
  assign busy = r_state == S_CALC;
  assign done = r_state == S_DONE;
  assign Q    = r_q;
  assign Rem  = r_rem;
  assign Z    = r_z;
  assign V    = r_v;
  assign DZ   = r_dz;
endmodule
